// File: rtl/llc_writeback_buffer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the writeback buffer and memory.
// The master modport is the buffer side; the slave modport is the memory side.
interface llc_writeback_buffer_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 13
);
  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awlock;
  logic [3:0]            m_axi_awcache;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [7:0]            m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
           m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
           m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/llc_writeback_buffer.sv
// LLC writeback buffer: queues evicted 64-byte lines in a circular FIFO and drains them one
// at a time as 8-beat AXI INCR write bursts. Optional store-to-load forwarding of pending
// lines is enabled by defining WB_FORWARD_EN.
module llc_writeback_buffer #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  S_W_VALID,
  input  logic [ADDR_WIDTH-1:0] S_W_ADDR,
  input  logic [511:0]          S_W_DATA,
  output logic                  S_W_READY,
  output logic                  S_W_COMPLETE,
  input  logic [ADDR_WIDTH-1:0] L_ADDR,
  output logic                  L_HIT,
  output logic [511:0]          L_DATA,
  output logic                  wb_error,
  llc_writeback_buffer_if.master axi
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]         count_q, count_d;
  logic [2:0]            beat_q, beat_d;
  logic                  wb_error_q, wb_error_d;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [511:0]          data_q [DEPTH];

  // Occupancy comes from registered count only, so a pop this cycle cannot open a slot.
  assign S_W_READY    = count_q < (PtrW + 1)'(DEPTH);
  assign push         = S_W_VALID && S_W_READY;
  assign S_W_COMPLETE = pop;
  assign wb_error     = wb_error_q;

  assign axi.m_axi_awid    = {ID_WIDTH{1'b0}};
  assign axi.m_axi_awlen   = 8'd7;
  assign axi.m_axi_awsize  = 3'b011;
  assign axi.m_axi_awburst = 2'b01;
  assign axi.m_axi_awlock  = 1'b0;
  assign axi.m_axi_awcache = 4'd0;
  assign axi.m_axi_awprot  = 3'd0;

  // Line storage: written at tail on accept; no reset needed, validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= {S_W_ADDR[ADDR_WIDTH-1:6], 6'd0};
      data_q[tail_q] <= S_W_DATA;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      wb_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      wb_error_q <= wb_error_d;
    end
  end

  // Burst FSM: next state, beat counter and AXI outputs for the head entry.
  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    pop               = 1'b0;
    axi.m_axi_awvalid = 1'b0;
    axi.m_axi_awaddr  = '0;
    axi.m_axi_wvalid  = 1'b0;
    axi.m_axi_wdata   = '0;
    axi.m_axi_wstrb   = 8'h00;
    axi.m_axi_wlast   = 1'b0;
    axi.m_axi_bready  = 1'b0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StAw;
      end
      StAw: begin
        axi.m_axi_awvalid = 1'b1;
        axi.m_axi_awaddr  = addr_q[head_q];
        if (axi.m_axi_awready) begin
          state_d = StW;
          beat_d  = '0;
        end
      end
      StW: begin
        axi.m_axi_wvalid = 1'b1;
        axi.m_axi_wdata  = DATA_WIDTH'(data_q[head_q][{beat_q, 6'd0} +: 64]);
        axi.m_axi_wstrb  = 8'hFF;
        axi.m_axi_wlast  = (beat_q == 3'd7);
        if (axi.m_axi_wready) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = StB;
        end
      end
      StB: begin
        axi.m_axi_bready = 1'b1;
        if (axi.m_axi_bvalid) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointers, occupancy and the sticky error flag.
  always_comb begin
    head_d     = pop  ? head_q + PtrW'(1) : head_q;
    tail_d     = push ? tail_q + PtrW'(1) : tail_q;
    count_d    = count_q;
    wb_error_d = wb_error_q | (pop && (axi.m_axi_bresp != 2'b00));
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef WB_FORWARD_EN
  logic [ADDR_WIDTH-1:0] l_line;
  logic [PtrW-1:0]       fwd_idx;
  logic                  unused_sig;

  assign l_line     = {L_ADDR[ADDR_WIDTH-1:6], 6'd0};
  assign unused_sig = ^{axi.m_axi_bid, S_W_ADDR[5:0], L_ADDR[5:0]};

  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    L_HIT   = 1'b0;
    L_DATA  = '0;
    fwd_idx = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PtrW'(i);
      if (((PtrW + 1)'(i) < count_q) && (addr_q[fwd_idx] == l_line)) begin
        L_HIT  = 1'b1;
        L_DATA = data_q[fwd_idx];
      end
    end
  end
`else
  logic unused_sig;

  assign unused_sig = ^{axi.m_axi_bid, S_W_ADDR[5:0], L_ADDR};
  assign L_HIT      = 1'b0;
  assign L_DATA     = '0;
`endif

endmodule

// File: tb/tb_llc_writeback_buffer.sv
// Scoreboard bench for llc_writeback_buffer: expected AW addresses and W beats are queued
// when lines are pushed and popped as the AXI channels hand them over.
module tb_llc_writeback_buffer;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;
  localparam int unsigned IW    = 13;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          S_W_VALID;
  logic [AW-1:0] S_W_ADDR;
  logic [511:0]  S_W_DATA;
  logic          S_W_READY;
  logic          S_W_COMPLETE;
  logic [AW-1:0] L_ADDR;
  logic          L_HIT;
  logic [511:0]  L_DATA;
  logic          wb_error;

  llc_writeback_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi_if ();

  llc_writeback_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .S_W_VALID    (S_W_VALID),
    .S_W_ADDR     (S_W_ADDR),
    .S_W_DATA     (S_W_DATA),
    .S_W_READY    (S_W_READY),
    .S_W_COMPLETE (S_W_COMPLETE),
    .L_ADDR       (L_ADDR),
    .L_HIT        (L_HIT),
    .L_DATA       (L_DATA),
    .wb_error     (wb_error),
    .axi          (axi_if)
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int            cyc = 0;
  logic [63:0]   exp_addr_q[$];
  logic [63:0]   exp_beat_q[$];
  int            exp_cmp = 0;
  int            n_cmp = 0;
  int            last_cmp_cyc = -10;
  int            beat_idx = 0;
  int            w_acc = 0;
  logic          stalled = 1'b0;
  logic [63:0]   stall_data = '0;
  logic          aw_en = 1'b1;
  logic          w_toggle = 1'b0;
  logic [1:0]    bresp_cfg = 2'b00;

  task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] make_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = base + 64'(k);
    return l;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory-side responder: inputs change 1 time unit after the rising edge.
  initial begin
    axi_if.m_axi_awready = 1'b0;
    axi_if.m_axi_wready  = 1'b0;
    axi_if.m_axi_bvalid  = 1'b0;
    axi_if.m_axi_bresp   = 2'b00;
    axi_if.m_axi_bid     = '0;
    forever begin
      @(posedge clk);
      #1;
      axi_if.m_axi_awready = aw_en;
      axi_if.m_axi_wready  = w_toggle ? ~axi_if.m_axi_wready : 1'b1;
      axi_if.m_axi_bvalid  = axi_if.m_axi_bready;
      axi_if.m_axi_bresp   = bresp_cfg;
    end
  end

  // Monitor: compares AXI handshakes against the scoreboard on the falling edge.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_addr_q.delete();
      exp_beat_q.delete();
      exp_cmp  = 0;
      beat_idx = 0;
      stalled  = 1'b0;
    end else begin
      if (axi_if.m_axi_awvalid && axi_if.m_axi_awready) begin
        if (exp_addr_q.size() == 0) check_eq("aw_unexpected", 1, 0);
        else check_eq("awaddr", axi_if.m_axi_awaddr, exp_addr_q.pop_front());
        check_eq("awlen", axi_if.m_axi_awlen, 7);
        check_eq("awsize", axi_if.m_axi_awsize, 3);
        check_eq("awburst", axi_if.m_axi_awburst, 1);
      end
      if (axi_if.m_axi_wvalid) begin
        if (stalled) check_eq("wdata_stable", axi_if.m_axi_wdata, stall_data);
        if (axi_if.m_axi_wready) begin
          if (exp_beat_q.size() == 0) check_eq("w_unexpected", 1, 0);
          else check_eq("wdata", axi_if.m_axi_wdata, exp_beat_q.pop_front());
          check_eq("wlast", axi_if.m_axi_wlast, beat_idx == 7);
          check_eq("wstrb", axi_if.m_axi_wstrb, 8'hFF);
          beat_idx = (beat_idx == 7) ? 0 : beat_idx + 1;
          w_acc++;
        end
      end
      stalled    = axi_if.m_axi_wvalid && !axi_if.m_axi_wready;
      stall_data = axi_if.m_axi_wdata;
      check_eq("complete", S_W_COMPLETE, axi_if.m_axi_bvalid && axi_if.m_axi_bready);
      if (axi_if.m_axi_bvalid && axi_if.m_axi_bready) begin
        exp_cmp--;
        n_cmp++;
        last_cmp_cyc = cyc;
      end
    end
  end

  // Offer one line; returns the cycle in which it was accepted, or -1 on timeout.
  task automatic push_line(input logic [63:0] addr, input logic [63:0] base, output int acc);
    int n = 0;
    acc       = -1;
    S_W_VALID = 1'b1;
    S_W_ADDR  = addr;
    S_W_DATA  = make_line(base);
    forever begin
      @(negedge clk);
      if (S_W_READY) break;
      n++;
      if (n > 300) break;
    end
    if (S_W_READY) begin
      acc = cyc;
      exp_addr_q.push_back(addr & ~64'h3F);
      for (int k = 0; k < 8; k++) exp_beat_q.push_back(base + 64'(k));
      exp_cmp++;
    end else begin
      check_eq("push_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    S_W_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_cmp != 0 || exp_addr_q.size() != 0 || exp_beat_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, acc3, w0, cmp0, n;
    reset     = 1'b1;
    S_W_VALID = 1'b0;
    S_W_ADDR  = '0;
    S_W_DATA  = '0;
    L_ADDR    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", S_W_READY, 1);
    check_eq("rst_awvalid", axi_if.m_axi_awvalid, 0);
    check_eq("rst_wvalid", axi_if.m_axi_wvalid, 0);
    check_eq("rst_bready", axi_if.m_axi_bready, 0);
    check_eq("rst_lhit", L_HIT, 0);
    check_eq("rst_error", wb_error, 0);
    @(posedge clk);
    #1;

    // Single line, minimum latency.
    push_line(64'h8000_1234, 64'd1, acc);
    check_eq("aw_early", axi_if.m_axi_awvalid, 0);
    @(posedge clk);
    #1;
    check_eq("aw_latency", axi_if.m_axi_awvalid, 1);
    wait_drain();
    check_eq("single_cmp", n_cmp, 1);
    check_eq("single_err", wb_error, 0);

    // Full buffer with AW stalled; third line waits for the first retirement.
    aw_en = 1'b0;
    push_line(64'h0000_2000, 64'h200, acc);
    push_line(64'h0000_3040, 64'h300, acc);
    @(negedge clk);
    check_eq("full_ready", S_W_READY, 0);
    @(posedge clk);
    #1;
    aw_en = 1'b1;
    push_line(64'h0000_4080, 64'h400, acc3);
    check_eq("third_accept_cyc", acc3, last_cmp_cyc + 1);
    wait_drain();
    check_eq("full_cmp", n_cmp, 4);

    // W backpressure: wready alternates every cycle.
    w_toggle = 1'b1;
    w0 = w_acc;
    push_line(64'h0000_5000, 64'h500, acc);
    wait_drain();
    check_eq("bp_beats", w_acc - w0, 8);
    w_toggle = 1'b0;

    // Error response sets a sticky flag; line still retires.
    bresp_cfg = 2'b10;
    push_line(64'h0000_6000, 64'h600, acc);
    wait_drain();
    check_eq("err_set", wb_error, 1);
    check_eq("err_cmp", n_cmp, 6);
    bresp_cfg = 2'b00;
    push_line(64'h0000_7000, 64'h700, acc);
    wait_drain();
    check_eq("err_sticky", wb_error, 1);

    // Forwarding lookup against two pending lines for the same address.
    aw_en = 1'b0;
    push_line(64'h0000_0100, 64'hA0, acc);
    push_line(64'h0000_0100, 64'hB0, acc);
    L_ADDR = 64'h13F;
    #1;
`ifdef WB_FORWARD_EN
    check_eq("fwd_hit", L_HIT, 1);
    check_eq("fwd_data", L_DATA, make_line(64'hB0));
`else
    check_eq("fwd_hit_off", L_HIT, 0);
    check_eq("fwd_data_off", L_DATA, 0);
`endif
    L_ADDR = 64'h140;
    #1;
    check_eq("fwd_miss", L_HIT, 0);
    aw_en = 1'b1;
    wait_drain();
    check_eq("fwd_cmp", n_cmp, 9);

    // Reset in the middle of a burst.
    w0 = w_acc;
    cmp0 = n_cmp;
    push_line(64'h0000_9000, 64'h900, acc);
    n = 0;
    while (w_acc - w0 < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_beats", w_acc - w0, 4);
    check_eq("mid_err_before", wb_error, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_wvalid", axi_if.m_axi_wvalid, 0);
    check_eq("mid_ready", S_W_READY, 1);
    check_eq("mid_complete", S_W_COMPLETE, 0);
    check_eq("mid_err_clr", wb_error, 0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("mid_no_cmp", n_cmp, cmp0);
    check_eq("mid_idle_aw", axi_if.m_axi_awvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
